cia_icr: RTL and testbench
==========================

# cia_icr

Interrupt control register for the CIA core: the stage directly downstream of the TOD block, timers, serial port and FLAG pin. It edge-detects each interrupt source, latches events into the ICR data register, and combines them with the ICR mask to drive the IRQ output. Reading ICR returns and clears the pending events. The 6526 and 8521 IRQ timing differences are selected by parameter.

## Interface
- `MODEL`, default 0: 0 = 6526 (IRQ output lags event by one PHI2 cycle); 1 = 8521/8520 (IRQ asserts on the event cycle).
- `clk` in 1: FPGA system clock; the only clock.
- `res_n` in 1: reset, asynchronous, active-low.
- `phi2_up` in 1: single-`clk` strobe at PHI2 rising edge.
- `phi2_dn` in 1: single-`clk` strobe at PHI2 falling edge; all state updates are gated by this strobe.
- `rd` in 1: bus read qualifier, valid at `phi2_dn`.
- `we` in 1: bus write qualifier, valid at `phi2_dn`.
- `addr` in 4: register address; ICR is at `'hD`.
- `data` in 8: write data.
- `ta_int` in 1: timer A underflow (level or pulse).
- `tb_int` in 1: timer B underflow.
- `tod_int` in 1: TOD alarm; may stay high for up to four PHI2 cycles.
- `sp_int` in 1: serial port byte complete.
- `flag_int` in 1: FLAG pin negative edge detected.
- `icr` out 8: read value `{irq, 2'b00, flags[4:0]}`.
- `irq_n` out 1: IRQ pin drive, active-low.

## Operation
- **Source order:** bit 0 = TA, 1 = TB, 2 = TOD, 3 = SP, 4 = FLAG.
- **Edge detection:** each source is sampled at `phi2_dn` into `src_prev[4:0]`. An event is `src & ~src_prev`, so a level held for N cycles gives exactly one event.
- **Flag set:** at `phi2_dn`, `flags <= flags_after_read | event`.
- **Read clear:** `rd && addr=='hD` at `phi2_dn` clears `flags` and `irq`.
  - An event in the same cycle as the read is not included in that read's returned value.
  - That event is kept in `flags` after the clear and is seen by the next read. No event is ever lost.
- **Mask write:** `we && addr=='hD` at `phi2_dn`: for each i in 4..0 with `data[i]=1`, `mask[i] <= data[7]`. Bits with `data[i]=0` are unchanged. `data[6:5]` are ignored.
- **IRQ condition:** `pend = |(flags_next & mask_next)`, evaluated on the post-update values.
  - Setting a mask bit for an already-pending flag therefore raises IRQ.
  - Clearing a mask bit does not lower an already-set `irq`. Only an ICR read clears `irq`.
- **irq register:**
  - `MODEL=0`: `irq` sets one `phi2_dn` after `pend` first becomes true (through a delay register `pend_d`).
  - `MODEL=1`: `irq` sets at the same `phi2_dn` as `pend`.
  - Once set, `irq` stays set until an ICR read.
- **Read vs. pending interrupt:** a read in the cycle where `irq` would set cancels it. If `pend` is still true after the clear (same-cycle event, masked), `irq` re-sets on the next evaluation under the MODEL timing.
- **Outputs:** `icr` is combinational from the registered `irq` and `flags`. `irq_n = ~irq`.
- **Register write:** a write to `'hD` never modifies `flags`.
- **Other addresses:** no effect.

## Timing
- Reset (`res_n` low, asynchronous): `flags`, `mask`, `src_prev`, `pend_d`, `irq` are all 0. Therefore `icr = 8'h00` and `irq_n = 1`. This holds immediately and while reset stays low.
- Reset released mid-operation: the first `phi2_dn` after release samples sources. A source already high at release produces an event, because `src_prev` = 0.
- Latency, source rising to `flags`: 1 `phi2_dn`.
- Latency to `irq_n` low:
  - `MODEL=1`: the same `phi2_dn`.
  - `MODEL=0`: the next `phi2_dn`.
- Read clear takes effect at the `phi2_dn` of the read cycle. `icr` shows 0 (plus any same-cycle events) from the following `clk`.
- `phi2_up` is unused except for being passed through with the other strobes. Nothing updates on `clk` edges without a strobe.

## Test plan
- **Reset:** pulse `res_n` low asynchronously between strobes -> `icr=8'h00`, `irq_n=1` without waiting for `clk`.
- **Unmasked event:** `ta_int` pulse, mask 0 -> `icr=8'h01`, `irq_n` stays 1. Read `'hD` -> returns `8'h01`, then `icr=8'h00`.
- **IRQ latency:** write `8'h84` (enable TOD), hold `tod_int` high for 4 cycles -> single event, `icr=8'h84`. `irq_n` low 1 cycle after the flag with `MODEL=0`, same cycle with `MODEL=1`. Read -> `8'h84`, `irq_n=1`.
- **Late enable:** with `flags[4]` pending and mask 0, write `8'h90` -> `irq_n` goes low per MODEL latency. Write `8'h10` -> `irq_n` stays low until a read.
- **Same-cycle event and read:** `tb_int` edge in the same cycle as an ICR read, mask enables TB -> read returns the prior value (TB bit 0). Next `icr=8'h02`, `irq` re-asserts. Second read returns `8'h82`.
- **Simultaneous events:** all five sources rise together, mask `8'h1F` -> `icr=8'h9F`. Write `8'h01` (clear TA mask) -> `irq` is unchanged.

Source files
------------

// File: rtl/cia_icr.sv
// CIA interrupt control register.
// Edge-detects the five interrupt sources, accumulates events in the ICR
// flag register, and combines them with the ICR mask to drive IRQ.
// A read of the ICR returns the pending flags and clears them together with
// irq.
// All state advances only on the phi2_dn strobe.
// MODEL selects the IRQ timing:
//   0 = 6526, irq follows pend one PHI2 cycle later.
//   1 = 8521, irq follows pend in the same cycle.
module cia_icr #(
    parameter int MODEL = 0
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_up,
    input  logic       phi2_dn,
    input  logic       rd,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] data,
    input  logic       ta_int,
    input  logic       tb_int,
    input  logic       tod_int,
    input  logic       sp_int,
    input  logic       flag_int,
    output logic [7:0] icr,
    output logic       irq_n
);

    localparam logic [3:0] ICR_ADDR = 4'hD;

    logic [4:0] src;
    logic [4:0] src_prev;
    logic [4:0] events;
    logic [4:0] flags;
    logic [4:0] flags_next;
    logic [4:0] mask;
    logic [4:0] mask_next;
    logic       icr_rd;
    logic       icr_wr;
    logic       pend;
    logic       pend_d;
    logic       irq_trig;
    logic       irq;
    logic       irq_next;

    // phi2_up and data[6:5] have no function in this register.
    logic       unused_inputs;
    assign unused_inputs = ^{phi2_up, data[6:5]};

    assign src    = {flag_int, sp_int, tod_int, tb_int, ta_int};
    assign events = src & ~src_prev;
    assign icr_rd = phi2_dn & rd & (addr == ICR_ADDR);
    assign icr_wr = phi2_dn & we & (addr == ICR_ADDR);

    // A read clears the old flags, but an event in the read cycle survives
    // the clear, so no event is ever lost.
    always_comb begin
        flags_next = (icr_rd ? 5'b0 : flags) | events;
    end

    // Set/clear mask write: data[7] is the value written to every selected bit.
    always_comb begin
        mask_next = mask;
        if (icr_wr) begin
            for (int i = 0; i < 5; i++) begin
                if (data[i]) begin
                    mask_next[i] = data[7];
                end
            end
        end
    end

    // pend is evaluated on the post-update flags and mask.
    // Enabling a mask bit for a flag that is already pending therefore
    // raises an interrupt.
    assign pend     = |(flags_next & mask_next);
    assign irq_trig = (MODEL == 0) ? pend_d : pend;

    // irq is sticky until an ICR read.
    // A read cancels a set in the same cycle; a still-true pend re-arms it
    // on the next evaluation.
    always_comb begin
        irq_next = icr_rd ? 1'b0 : (irq | irq_trig);
    end

    // State register: everything advances on the PHI2 falling-edge strobe only.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            src_prev <= 5'b0;
            flags    <= 5'b0;
            mask     <= 5'b0;
            pend_d   <= 1'b0;
            irq      <= 1'b0;
        end else if (phi2_dn) begin
            src_prev <= src;
            flags    <= flags_next;
            mask     <= mask_next;
            pend_d   <= pend;
            irq      <= irq_next;
        end
    end

    assign icr   = {irq, 2'b00, flags};
    assign irq_n = ~irq;

endmodule

// File: tb/tb_cia_icr.sv
// Bench for cia_icr.
// Runs a 6526 instance and an 8521 instance side by side on the same inputs.
// Both are compared against a per-PHI2-cycle reference model of the ICR rules.
module tb_cia_icr;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       phi2_up = 1'b0;
    logic       phi2_dn = 1'b0;
    logic       rd = 1'b0;
    logic       we = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] data = 8'h00;
    logic       ta_int = 1'b0;
    logic       tb_int = 1'b0;
    logic       tod_int = 1'b0;
    logic       sp_int = 1'b0;
    logic       flag_int = 1'b0;
    logic [7:0] icr0;
    logic [7:0] icr1;
    logic       irq_n0;
    logic       irq_n1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int   m_flags = 0;
    int   m_mask  = 0;
    int   m_prev  = 0;
    bit   m_irq0  = 0;
    bit   m_irq1  = 0;
    bit   pend_hist[$];

    always #5 clk = ~clk;

    cia_icr #(.MODEL(0)) dut0 (
        .clk(clk), .res_n(res_n), .phi2_up(phi2_up), .phi2_dn(phi2_dn),
        .rd(rd), .we(we), .addr(addr), .data(data),
        .ta_int(ta_int), .tb_int(tb_int), .tod_int(tod_int),
        .sp_int(sp_int), .flag_int(flag_int),
        .icr(icr0), .irq_n(irq_n0)
    );

    cia_icr #(.MODEL(1)) dut1 (
        .clk(clk), .res_n(res_n), .phi2_up(phi2_up), .phi2_dn(phi2_dn),
        .rd(rd), .we(we), .addr(addr), .data(data),
        .ta_int(ta_int), .tb_int(tb_int), .tod_int(tod_int),
        .sp_int(sp_int), .flag_int(flag_int),
        .icr(icr1), .irq_n(irq_n1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_icr(input bit irq_bit);
        return 8'((irq_bit ? 128 : 0) + m_flags);
    endfunction

    task automatic model_reset();
        m_flags = 0;
        m_mask  = 0;
        m_prev  = 0;
        m_irq0  = 0;
        m_irq1  = 0;
        pend_hist.delete();
        pend_hist.push_back(1'b0);
    endtask

    task automatic check_both(input string tag);
        check({tag, "_icr0"},  icr0, m_icr(m_irq0));
        check({tag, "_icr1"},  icr1, m_icr(m_irq1));
        check({tag, "_irqn0"}, {7'b0, irq_n0}, {7'b0, !m_irq0});
        check({tag, "_irqn1"}, {7'b0, irq_n1}, {7'b0, !m_irq1});
    endtask

    // One PHI2 cycle: up strobe, settle, down strobe; model advanced in step.
    task automatic phi2_cycle(input logic r, input logic w, input logic [3:0] a,
                              input logic [7:0] d, input logic [4:0] s);
        bit hit_rd;
        bit hit_wr;
        int ev;
        bit pend;
        @(negedge clk);
        rd = r; we = w; addr = a; data = d;
        {flag_int, sp_int, tod_int, tb_int, ta_int} = s;
        phi2_up = 1'b1;
        @(negedge clk);
        phi2_up = 1'b0;
        @(negedge clk);
        hit_rd = r && (a == 4'hD);
        hit_wr = w && (a == 4'hD);
        if (hit_rd) begin
            check("read_val0", icr0, m_icr(m_irq0));
            check("read_val1", icr1, m_icr(m_irq1));
        end
        phi2_dn = 1'b1;
        @(posedge clk);
        #1;
        phi2_dn = 1'b0;
        // reference: rising edges become events; read empties then events land
        ev = int'(s) & ~m_prev & 31;
        m_prev = int'(s);
        m_flags = (hit_rd ? 0 : m_flags) | ev;
        if (hit_wr) begin
            for (int i = 0; i < 5; i++) begin
                if (d[i]) begin
                    if (d[7]) m_mask = m_mask | (1 << i);
                    else      m_mask = m_mask & ~(1 << i);
                end
            end
        end
        pend = (m_flags & m_mask) != 0;
        // 8521: responds to this cycle's pend; 6526: to the previous cycle's
        m_irq1 = hit_rd ? 1'b0 : (m_irq1 | pend);
        m_irq0 = hit_rd ? 1'b0 : (m_irq0 | pend_hist[pend_hist.size() - 1]);
        pend_hist.push_back(pend);
        if (pend_hist.size() > 4) void'(pend_hist.pop_front());
        check_both("cyc");
    endtask

    task automatic idle(input logic [4:0] s);
        phi2_cycle(1'b0, 1'b0, 4'h0, 8'h00, s);
    endtask

    task automatic rd_icr(input logic [4:0] s);
        phi2_cycle(1'b1, 1'b0, 4'hD, 8'h00, s);
    endtask

    task automatic wr_icr(input logic [7:0] d, input logic [4:0] s);
        phi2_cycle(1'b0, 1'b1, 4'hD, d, s);
    endtask

    task automatic reset_pulse(input logic [4:0] s_hold);
        @(negedge clk);
        #2;
        res_n = 1'b0;
        {flag_int, sp_int, tod_int, tb_int, ta_int} = s_hold;
        #1;
        check("rst_async_icr0", icr0, 8'h00);
        check("rst_async_icr1", icr1, 8'h00);
        check("rst_async_irqn0", {7'b0, irq_n0}, 8'h01);
        check("rst_async_irqn1", {7'b0, irq_n1}, 8'h01);
        repeat (3) @(negedge clk);
        check("rst_hold_icr0", icr0, 8'h00);
        check("rst_hold_icr1", icr1, 8'h00);
        res_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [4:0] s_r;
        logic       r_r;
        logic       w_r;
        logic [3:0] a_r;
        logic [7:0] d_r;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_icr0", icr0, 8'h00);
        check("rst_icr1", icr1, 8'h00);
        check("rst_irqn0", {7'b0, irq_n0}, 8'h01);
        check("rst_irqn1", {7'b0, irq_n1}, 8'h01);
        res_n = 1'b1;

        // unmasked TA event
        idle(5'b00001);
        check("ta_flag0", icr0, 8'h01);
        check("ta_irqn1", {7'b0, irq_n1}, 8'h01);
        idle(5'b00000);
        rd_icr(5'b00000);
        check("ta_clr1", icr1, 8'h00);

        // TOD enabled, held four cycles: a single event
        wr_icr(8'h84, 5'b00000);
        idle(5'b00100);
        check("tod_m1_same", icr1, 8'h84);
        check("tod_m0_lag", icr0, 8'h04);
        idle(5'b00100);
        check("tod_m0_next", icr0, 8'h84);
        idle(5'b00100);
        idle(5'b00100);
        idle(5'b00000);
        rd_icr(5'b00000);
        check("tod_clr_irqn0", {7'b0, irq_n0}, 8'h01);

        // late enable of a pending FLAG, then a mask clear does not drop irq
        idle(5'b10000);
        idle(5'b00000);
        check("late_pending", icr1, 8'h10);
        wr_icr(8'h90, 5'b00000);
        check("late_m1", icr1, 8'h90);
        check("late_m0", icr0, 8'h10);
        idle(5'b00000);
        check("late_m0_next", icr0, 8'h90);
        wr_icr(8'h10, 5'b00000);
        idle(5'b00000);
        check("late_hold_irqn0", {7'b0, irq_n0}, 8'h00);
        check("late_hold_irqn1", {7'b0, irq_n1}, 8'h00);
        rd_icr(5'b00000);

        // TB event in the same cycle as a read
        wr_icr(8'h82, 5'b00000);
        rd_icr(5'b00010);
        check("same_kept0", icr0, 8'h02);
        check("same_kept1", icr1, 8'h02);
        idle(5'b00010);
        check("same_rearm0", icr0, 8'h82);
        check("same_rearm1", icr1, 8'h82);
        rd_icr(5'b00010);
        idle(5'b00000);

        // all sources together, then TA mask cleared leaves irq set
        wr_icr(8'h9F, 5'b00000);
        idle(5'b11111);
        check("all_m1", icr1, 8'h9F);
        idle(5'b11111);
        check("all_m0", icr0, 8'h9F);
        wr_icr(8'h01, 5'b11111);
        check("all_unmask0", icr0, 8'h9F);
        check("all_unmask1", icr1, 8'h9F);
        rd_icr(5'b11111);
        idle(5'b00000);

        // randomized traffic
        s_r = 5'b0;
        for (int n = 0; n < 600; n++) begin
            s_r = s_r ^ 5'($urandom & $urandom);
            r_r = ($urandom_range(0, 3) == 0);
            w_r = ($urandom_range(0, 4) == 0);
            a_r = ($urandom_range(0, 3) != 0) ? 4'hD : 4'($urandom);
            d_r = 8'($urandom);
            phi2_cycle(r_r, w_r, a_r, d_r, s_r);
        end

        // reset mid-operation, released with sources already high
        wr_icr(8'h9F, s_r);
        reset_pulse(5'b00101);
        idle(5'b00101);
        check("rel_event0", icr0, 8'h05);
        check("rel_event1", icr1, 8'h05);
        idle(5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
